// File: rtl/regfile_op_sequencer_if.sv
// Bundles the instruction handshake and register-file port of regfile_op_sequencer.
// slave = sequencer side, master = upstream/register-file side; ovf exists only with OVF_TRAP_EN.
// Purely wiring, no latency or backpressure of its own.
interface regfile_op_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] Adr_register_to_A;
    logic [ADDR_W-1:0] Adr_register_to_B;
    logic [DATA_W-1:0] data_to_A;
    logic [DATA_W-1:0] data_to_B;
    logic              write;
    logic [ADDR_W-1:0] Adr_register_to_save;
    logic [DATA_W-1:0] data_from_ctrl;
    logic              done;
    logic              illegal;
`ifdef OVF_TRAP_EN
    logic              ovf;

    modport slave (
        input  instr_valid, instr, data_to_A, data_to_B,
        output instr_ready, Adr_register_to_A, Adr_register_to_B, write,
               Adr_register_to_save, data_from_ctrl, done, illegal, ovf
    );
    modport master (
        output instr_valid, instr, data_to_A, data_to_B,
        input  instr_ready, Adr_register_to_A, Adr_register_to_B, write,
               Adr_register_to_save, data_from_ctrl, done, illegal, ovf
    );
`else
    modport slave (
        input  instr_valid, instr, data_to_A, data_to_B,
        output instr_ready, Adr_register_to_A, Adr_register_to_B, write,
               Adr_register_to_save, data_from_ctrl, done, illegal
    );
    modport master (
        output instr_valid, instr, data_to_A, data_to_B,
        input  instr_ready, Adr_register_to_A, Adr_register_to_B, write,
               Adr_register_to_save, data_from_ctrl, done, illegal
    );
`endif
endinterface

// File: rtl/regfile_op_sequencer.sv
// Multicycle IDLE/READ/EXEC/WB sequencer driving registerFile; OVF_TRAP_EN traps signed overflow.
// Latency: accept edge to done/write-back is 3 cycles; one instruction per 4 cycles.
// Backpressure: instr_ready only in IDLE; instr_valid in any other state is ignored.
module regfile_op_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_op_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_adr_a;
    logic [ADDR_W-1:0] r_adr_b;
    logic [DATA_W-1:0] r_result;
    logic              r_wr;
    logic              r_illegal;

    logic [3:0]        w_op;
    logic [ADDR_W-1:0] w_rd;
    logic [15:0]       w_imm;
    logic [DATA_W-1:0] w_se;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_sum_ab;
    logic [DATA_W-1:0] w_diff_ab;
    logic [DATA_W-1:0] w_sum_ai;
    logic [DATA_W-1:0] w_result;
    logic              w_wr;
    logic              w_illegal;
    logic              w_accept;

    assign w_op      = r_instr[31:28];
    assign w_rd      = ADDR_W'(r_instr[27:24]);
    assign w_imm     = r_instr[15:0];
    assign w_se      = {{(DATA_W-16){w_imm[15]}}, w_imm};
    assign w_a       = bus.data_to_A;
    assign w_b       = bus.data_to_B;
    assign w_sum_ab  = w_a + w_b;
    assign w_diff_ab = w_a - w_b;
    assign w_sum_ai  = w_a + w_se;
    assign w_accept  = (r_state == S_IDLE) && bus.instr_valid && !rst;

    assign bus.Adr_register_to_A = r_adr_a;
    assign bus.Adr_register_to_B = r_adr_b;

`ifdef OVF_TRAP_EN
    logic w_ovf_det;
    logic r_ovf;

    // Signed overflow: operands agree in sign but the wrapped result does not.
    always_comb begin
        w_ovf_det = 1'b0;
        case (w_op)
            4'd1:    w_ovf_det = (w_a[DATA_W-1] == w_b[DATA_W-1])  && (w_sum_ab[DATA_W-1]  != w_a[DATA_W-1]);
            4'd2:    w_ovf_det = (w_a[DATA_W-1] != w_b[DATA_W-1])  && (w_diff_ab[DATA_W-1] != w_a[DATA_W-1]);
            4'd6:    w_ovf_det = (w_a[DATA_W-1] == w_se[DATA_W-1]) && (w_sum_ai[DATA_W-1]  != w_a[DATA_W-1]);
            default: w_ovf_det = 1'b0;
        endcase
    end
`endif

    always_comb begin
        w_result  = '0;
        w_wr      = 1'b1;
        w_illegal = 1'b0;
        case (w_op)
            4'd0:    w_wr = 1'b0;
            4'd1:    w_result = w_sum_ab;
            4'd2:    w_result = w_diff_ab;
            4'd3:    w_result = w_a & w_b;
            4'd4:    w_result = w_a | w_b;
            4'd5:    w_result = DATA_W'($signed(w_a) < $signed(w_b));
            4'd6:    w_result = w_sum_ai;
            4'd7:    w_result = DATA_W'({w_imm, 16'h0000});
            4'd8:    w_result = w_a;
            default: begin
                w_wr      = 1'b0;
                w_illegal = 1'b1;
            end
        endcase
`ifdef OVF_TRAP_EN
        if (w_ovf_det) begin
            w_wr      = 1'b0;
            w_illegal = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt              = r_state;
        bus.instr_ready          = 1'b0;
        bus.write                = 1'b0;
        bus.Adr_register_to_save = '0;
        bus.data_from_ctrl       = '0;
        bus.done                 = 1'b0;
        bus.illegal              = 1'b0;
`ifdef OVF_TRAP_EN
        bus.ovf                  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                bus.instr_ready = !rst;
                if (bus.instr_valid) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: w_state_nxt = S_EXEC;
            S_EXEC: w_state_nxt = S_WB;
            S_WB: begin
                bus.write                = r_wr;
                bus.Adr_register_to_save = w_rd;
                bus.data_from_ctrl       = r_result;
                bus.done                 = 1'b1;
                bus.illegal              = r_illegal;
`ifdef OVF_TRAP_EN
                bus.ovf                  = r_ovf;
`endif
                w_state_nxt              = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read addresses load at accept so they are stable through READ and EXEC, then hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr   <= '0;
            r_adr_a   <= '0;
            r_adr_b   <= '0;
            r_result  <= '0;
            r_wr      <= 1'b0;
            r_illegal <= 1'b0;
`ifdef OVF_TRAP_EN
            r_ovf     <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_instr <= bus.instr;
                r_adr_a <= ADDR_W'(bus.instr[23:20]);
                r_adr_b <= ADDR_W'(bus.instr[19:16]);
            end
            if (r_state == S_EXEC) begin
                r_result  <= w_result;
                r_wr      <= w_wr;
                r_illegal <= w_illegal;
`ifdef OVF_TRAP_EN
                r_ovf     <= w_ovf_det;
`endif
            end
        end
    end
endmodule
